id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Parametrised operand-resolution and hazard unit for the decode stage of the RV32I pipeline. It holds a scoreboard of the destination registers in flight in the STAGES pipeline stages after decode. It forwards the youngest available result to each source operand and raises a stall when the youngest producer's result is not yet ready, covering load-use and any multi-cycle result. It sits beside the decode logic, between the regfile read ports and the decode/execute register, and feeds `stallreq_out` to the pipeline controller.

## Interface
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register address width.
- `STAGES`, 3: number of tracked post-decode stages. Index 0 is the stage right after decode; index STAGES-1 is the last stage before regfile write.
- `SEL_W`, 2: forward-select width. Must satisfy 2^SEL_W ≥ STAGES+1.

Ports:
- `clk_in` in 1: clock. One clock domain.
- `reset_in` in 1: synchronous, active-high reset.
- `issue_valid_in` in 1: decode holds a valid instruction.
- `issue_rd_in` in ADDR_W: destination register of the decode instruction.
- `issue_we_in` in 1: the decode instruction writes `issue_rd_in`.
- `rs1_addr_in`, `rs2_addr_in` in ADDR_W: source register addresses.
- `rs1_ren_in`, `rs2_ren_in` in 1: source read enables.
- `rs1_rdata_in`, `rs2_rdata_in` in DATA_W: regfile read data.
- `stage_wdata_in` in STAGES*DATA_W: result of the instruction now in stage k, in bits [k*DATA_W +: DATA_W].
- `stage_wvld_in` in STAGES: bit k is 1 when the stage-k result is final. A load in its address stage drives 0.
- `hold_in` in 1: the pipeline is frozen downstream; the scoreboard must not advance.
- `flush_in` in 1: the decode instruction is killed and must not enter stage 0.
- `op1_out`, `op2_out` out DATA_W: resolved operands.
- `fwd1_sel_out`, `fwd2_sel_out` out SEL_W: source of each operand. 0 = regfile or zero; k+1 = stage k.
- `stallreq_out` out 1: stall request to the controller.
- `stall_count_out` out 16: number of stall cycles, saturating.

## Operation
- The scoreboard has STAGES entries. Each entry holds {valid, we, rd}.
- An entry k matches operand n when all of the following hold:
  - entry.valid and entry.we;
  - entry.rd == rsn_addr_in;
  - rsn_ren_in = 1;
  - rsn_addr_in ≠ 0.
- Operand resolution is combinational and done per operand:
  - If rsn_addr_in = 0 or rsn_ren_in = 0: output 0 and sel 0.
  - Else if there is no match: output rsn_rdata_in and sel 0.
  - Else take the lowest matching k (youngest wins). If stage_wvld_in[k]=1: output stage k data and sel k+1.
  - Else (youngest match not ready): output rsn_rdata_in, sel 0, and the operand is pending.
- `stallreq_out` = issue_valid_in & (op1 pending | op2 pending).
- Scoreboard update on each rising edge of `clk_in`:
  - reset_in: all entries invalid, stall_count_out = 0.
  - Else if hold_in: entries unchanged. The counter increments if stallreq_out.
  - Otherwise entries shift k → k+1 and the oldest entry is dropped. Entry 0 loads {1, issue_we_in, issue_rd_in} if issue_valid_in & ~stallreq_out & ~flush_in; otherwise entry 0 loads a bubble {0, 0, 0}.
- Counter rule: stall_count_out increments when stallreq_out=1 and saturates at 16'hFFFF.
- Simultaneous events:
  - flush_in with stallreq_out: a bubble is inserted and the flush wins.
  - hold_in with flush_in: hold wins for that cycle, so the controller must keep flush_in asserted.
- Reset in the middle of a stall clears every entry. On the first cycle after reset, stallreq_out = 0 and all operands come from the regfile.

## Timing
- All data outputs are combinational from the current inputs and scoreboard state, with zero-cycle latency.
- Reset values: stallreq_out = 0, fwd*_sel_out = 0, stall_count_out = 0. After reset, op*_out equals regfile data, or 0 for x0.
- A load in stage 0 with a dependent instruction in decode gives exactly one stall cycle. The next cycle the load is in stage 1 with stage_wvld_in[1]=1 and its data is forwarded.
- A producer that needs N cycles to become valid stalls the consumer for N cycles. The stall releases in the same cycle that stage_wvld_in goes high.
- The regfile is write-before-read at the end of stage STAGES-1. Once an entry shifts out, the regfile data is current.

## Test plan
- ALU chain: addi x5 enters stage 0 with stage_wdata[0]=0x11 and vld=1; decode reads rs1=x5 → op1_out=0x11, fwd1_sel_out=1, no stall.
- Load-use: lw x7 in stage 0 with vld[0]=0, decode add rs2=x7 → stallreq_out=1 for 1 cycle and entry 0 becomes a bubble. Next cycle the load is in stage 1 with data 0xDEADBEEF and vld=1 → op2_out=0xDEADBEEF, fwd2_sel_out=2, stall_count_out=1.
- Youngest wins: x3 is pending in stage 0 (0xA, valid) and stage 2 (0xB) → op1_out=0xA. Repeat with stage 0 vld=0 → stall, even though stage 2 is ready.
- x0 and disabled reads: entry rd=0 with we=1 and rs1=0 → op1_out=0, no stall. Matching rd with rs2_ren_in=0 → no stall.
- Hold/flush: hold_in=1 for 3 cycles during a stall → entries frozen, counter +3. flush_in=1 → next entry 0 is invalid and a later read of issue_rd gets regfile data.
- Reset mid-stall, then counter saturation: force 65540 stall cycles → stall_count_out=16'hFFFF. Assert reset_in → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage operand resolution and hazard unit: tracks in-flight destination
// registers, forwards the youngest ready result and requests a stall otherwise.
module id_hazard_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     issue_valid_in,
    input  logic [ADDR_W-1:0]        issue_rd_in,
    input  logic                     issue_we_in,
    input  logic [ADDR_W-1:0]        rs1_addr_in,
    input  logic [ADDR_W-1:0]        rs2_addr_in,
    input  logic                     rs1_ren_in,
    input  logic                     rs2_ren_in,
    input  logic [DATA_W-1:0]        rs1_rdata_in,
    input  logic [DATA_W-1:0]        rs2_rdata_in,
    input  logic [STAGES*DATA_W-1:0] stage_wdata_in,
    input  logic [STAGES-1:0]        stage_wvld_in,
    input  logic                     hold_in,
    input  logic                     flush_in,
    output logic [DATA_W-1:0]        op1_out,
    output logic [DATA_W-1:0]        op2_out,
    output logic [SEL_W-1:0]         fwd1_sel_out,
    output logic [SEL_W-1:0]         fwd2_sel_out,
    output logic                     stallreq_out,
    output logic [15:0]              stall_count_out
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    entry_t sb [STAGES];
    logic   pend1;
    logic   pend2;

    // Result packs {pending, sel, data} for one source operand.
    function automatic logic [SEL_W+DATA_W:0] resolve(
        input logic [ADDR_W-1:0] addr,
        input logic              ren,
        input logic [DATA_W-1:0] rdata
    );
        logic              found;
        logic              pending;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        // NOTE: every result is given a value before any condition is tested, so
        // no path through the combinational logic can leave one unassigned (no latch).
        found   = 1'b0;
        pending = 1'b0;
        sel     = '0;
        data    = '0;
        if (ren && addr != '0) begin
            data = rdata;
            for (int k = 0; k < STAGES; k++) begin
                if (!found && sb[k].valid && sb[k].we && sb[k].rd == addr) begin
                    found = 1'b1;
                    if (stage_wvld_in[k]) begin
                        data = stage_wdata_in[k*DATA_W +: DATA_W];
                        sel  = SEL_W'(k + 1);
                    end else begin
                        pending = 1'b1;
                    end
                end
            end
        end
        return {pending, sel, data};
    endfunction

    assign {pend1, fwd1_sel_out, op1_out} = resolve(rs1_addr_in, rs1_ren_in, rs1_rdata_in);
    assign {pend2, fwd2_sel_out, op2_out} = resolve(rs2_addr_in, rs2_ren_in, rs2_rdata_in);

    assign stallreq_out = issue_valid_in & (pend1 | pend2);

    // NOTE: state uses non-blocking assignments so every entry shifts from its
    // pre-edge value; the scoreboard entries are control state and are all reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int k = 0; k < STAGES; k++) sb[k] <= BUBBLE;
            stall_count_out <= '0;
        end else begin
            if (stallreq_out && stall_count_out != 16'hFFFF)
                stall_count_out <= stall_count_out + 16'd1;
            if (!hold_in) begin
                for (int k = STAGES - 1; k > 0; k--) sb[k] <= sb[k-1];
                // A stalled or flushed decode instruction leaves a bubble behind.
                sb[0] <= (issue_valid_in && !stallreq_out && !flush_in)
                         ? {1'b1, issue_we_in, issue_rd_in} : BUBBLE;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: directed scenarios plus random
// traffic compared against a queue-based model of the in-flight instructions.
module tb_id_hazard_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int STAGES = 3;
    localparam int SEL_W  = 2;

    logic                     clk_in = 1'b0;
    logic                     reset_in;
    logic                     issue_valid_in;
    logic [ADDR_W-1:0]        issue_rd_in;
    logic                     issue_we_in;
    logic [ADDR_W-1:0]        rs1_addr_in, rs2_addr_in;
    logic                     rs1_ren_in, rs2_ren_in;
    logic [DATA_W-1:0]        rs1_rdata_in, rs2_rdata_in;
    logic [STAGES*DATA_W-1:0] stage_wdata_in;
    logic [STAGES-1:0]        stage_wvld_in;
    logic                     hold_in, flush_in;
    logic [DATA_W-1:0]        op1_out, op2_out;
    logic [SEL_W-1:0]         fwd1_sel_out, fwd2_sel_out;
    logic                     stallreq_out;
    logic [15:0]              stall_count_out;

    id_hazard_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES), .SEL_W(SEL_W)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in), .issue_we_in(issue_we_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .rs1_ren_in(rs1_ren_in), .rs2_ren_in(rs2_ren_in),
        .rs1_rdata_in(rs1_rdata_in), .rs2_rdata_in(rs2_rdata_in),
        .stage_wdata_in(stage_wdata_in), .stage_wvld_in(stage_wvld_in),
        .hold_in(hold_in), .flush_in(flush_in),
        .op1_out(op1_out), .op2_out(op2_out),
        .fwd1_sel_out(fwd1_sel_out), .fwd2_sel_out(fwd2_sel_out),
        .stallreq_out(stallreq_out), .stall_count_out(stall_count_out)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of in-flight instructions, index 0 is the youngest.
    typedef struct {
        bit       valid;
        bit       we;
        bit [4:0] rd;
    } instr_t;

    instr_t      pipe [$];
    int unsigned m_cnt;
    bit          m_stall;

    function automatic void model_op(input logic [4:0] a, input logic en, input logic [31:0] rf,
                                     output logic [31:0] d, output logic [1:0] s, output bit p);
        d = 0; s = 0; p = 0;
        if (!en || a == 0) return;
        d = rf;
        foreach (pipe[i]) begin
            if (pipe[i].valid && pipe[i].we && pipe[i].rd == a) begin
                if (stage_wvld_in[i]) begin
                    d = stage_wdata_in[i*DATA_W +: DATA_W];
                    s = 2'(i + 1);
                end else begin
                    p = 1;
                end
                return;
            end
        end
    endfunction

    function automatic void model_reset();
        instr_t b;
        b = '{0, 0, 0};
        pipe = {};
        repeat (STAGES) pipe.push_back(b);
        m_cnt = 0;
    endfunction

    function automatic void model_clock();
        instr_t e;
        if (reset_in) begin
            model_reset();
            return;
        end
        if (m_stall && m_cnt < 16'hFFFF) m_cnt++;
        if (!hold_in) begin
            if (issue_valid_in && !m_stall && !flush_in) e = '{1, issue_we_in, issue_rd_in};
            else e = '{0, 0, 0};
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endfunction

    // Inputs are set just after a falling edge; outputs are sampled 1 time unit later.
    task automatic tick(input bit cmp);
        logic [31:0] d1, d2;
        logic [1:0]  s1, s2;
        bit          p1, p2;
        #1;
        model_op(rs1_addr_in, rs1_ren_in, rs1_rdata_in, d1, s1, p1);
        model_op(rs2_addr_in, rs2_ren_in, rs2_rdata_in, d2, s2, p2);
        m_stall = issue_valid_in && (p1 || p2);
        if (cmp) begin
            check("op1", op1_out, d1);
            check("op2", op2_out, d2);
            check("sel1", 32'(fwd1_sel_out), 32'(s1));
            check("sel2", 32'(fwd2_sel_out), 32'(s2));
            check("stall", 32'(stallreq_out), 32'(m_stall));
            check("count", 32'(stall_count_out), m_cnt);
        end
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
    endtask

    task automatic issue(input logic [4:0] rd, input logic we);
        issue_valid_in = 1; issue_rd_in = rd; issue_we_in = we;
    endtask

    int unsigned base;

    initial begin
        reset_in = 1; issue_valid_in = 0; issue_rd_in = 0; issue_we_in = 0;
        rs1_addr_in = 0; rs2_addr_in = 0; rs1_ren_in = 0; rs2_ren_in = 0;
        rs1_rdata_in = 0; rs2_rdata_in = 0; stage_wdata_in = '0; stage_wvld_in = '0;
        hold_in = 0; flush_in = 0;
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);

        // Reset state: everything comes from the regfile.
        rs1_addr_in = 5; rs1_ren_in = 1; rs1_rdata_in = 32'h77;
        #1;
        check("rst_op1", op1_out, 32'h77);
        check("rst_sel1", 32'(fwd1_sel_out), 0);
        check("rst_stall", 32'(stallreq_out), 0);
        check("rst_count", 32'(stall_count_out), 0);
        tick(1);
        reset_in = 0; rs1_ren_in = 0;

        // ALU chain.
        issue(5, 1); tick(1);
        issue_valid_in = 0; rs1_addr_in = 5; rs1_ren_in = 1; rs1_rdata_in = 32'h99;
        stage_wdata_in[0 +: 32] = 32'h11; stage_wvld_in = 3'b001;
        #1;
        check("alu_op1", op1_out, 32'h11);
        check("alu_sel1", 32'(fwd1_sel_out), 1);
        check("alu_stall", 32'(stallreq_out), 0);
        tick(1);

        // Load-use: one stall, then forward from stage 1.
        rs1_ren_in = 0; stage_wvld_in = 0; issue(7, 1); tick(1);
        issue(8, 1); rs2_addr_in = 7; rs2_ren_in = 1; rs2_rdata_in = 32'h22;
        #1;
        check("lu_stall", 32'(stallreq_out), 1);
        tick(1);
        issue_valid_in = 0; stage_wvld_in = 3'b010; stage_wdata_in[32 +: 32] = 32'hDEADBEEF;
        #1;
        check("lu_op2", op2_out, 32'hDEADBEEF);
        check("lu_sel2", 32'(fwd2_sel_out), 2);
        check("lu_count", 32'(stall_count_out), 1);
        check("lu_nostall", 32'(stallreq_out), 0);
        tick(1);

        // Youngest wins.
        rs2_ren_in = 0; stage_wvld_in = 0;
        issue(3, 1); tick(1);
        issue_valid_in = 0; tick(1);
        issue(3, 1); tick(1);
        issue(0, 0); rs1_addr_in = 3; rs1_ren_in = 1; rs1_rdata_in = 32'h33;
        stage_wdata_in[0 +: 32] = 32'hA; stage_wdata_in[64 +: 32] = 32'hB; stage_wvld_in = 3'b101;
        #1;
        check("yw_op1", op1_out, 32'hA);
        check("yw_sel1", 32'(fwd1_sel_out), 1);
        stage_wvld_in = 3'b100;
        #1;
        check("yw_stall", 32'(stallreq_out), 1);
        check("yw_op1_rf", op1_out, 32'h33);
        tick(1);

        // x0 and disabled reads.
        rs1_ren_in = 0; stage_wvld_in = 0; issue(0, 1); tick(1);
        rs1_addr_in = 0; rs1_ren_in = 1; rs1_rdata_in = 32'h55;
        #1;
        check("x0_op1", op1_out, 0);
        check("x0_stall", 32'(stallreq_out), 0);
        tick(1);
        rs1_ren_in = 0; issue(9, 1); tick(1);
        rs2_addr_in = 9; rs2_ren_in = 0;
        #1;
        check("dis_stall", 32'(stallreq_out), 0);
        check("dis_op2", op2_out, 0);
        tick(1);

        // Hold freezes the scoreboard while the counter keeps counting.
        issue(10, 1); tick(1);
        issue(11, 1); rs1_addr_in = 10; rs1_ren_in = 1; rs1_rdata_in = 32'h10;
        stage_wvld_in = 3'b010; stage_wdata_in[32 +: 32] = 32'hCAFE; hold_in = 1;
        base = m_cnt;
        repeat (3) tick(1);
        #1;
        check("hold_count", 32'(stall_count_out), base + 3);
        hold_in = 0;
        #1;
        check("hold_frozen", 32'(stallreq_out), 1);
        tick(1);
        check("hold_fwd", op1_out, 32'hCAFE);
        rs1_ren_in = 0; tick(1);

        // Flush inserts a bubble.
        issue(12, 1); flush_in = 1; tick(1);
        flush_in = 0; rs1_addr_in = 12; rs1_ren_in = 1; rs1_rdata_in = 32'h1234; stage_wvld_in = 3'b111;
        #1;
        check("fl_op1", op1_out, 32'h1234);
        check("fl_sel1", 32'(fwd1_sel_out), 0);
        tick(1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset_in       = ($urandom_range(99) == 0);
            hold_in        = ($urandom_range(99) < 15);
            flush_in       = ($urandom_range(99) < 10);
            issue_valid_in = ($urandom_range(99) < 80);
            issue_we_in    = $urandom_range(1);
            issue_rd_in    = 5'($urandom_range(3));
            rs1_addr_in    = 5'($urandom_range(3));
            rs2_addr_in    = 5'($urandom_range(3));
            rs1_ren_in     = ($urandom_range(99) < 80);
            rs2_ren_in     = ($urandom_range(99) < 80);
            rs1_rdata_in   = $urandom;
            rs2_rdata_in   = $urandom;
            stage_wvld_in  = 3'($urandom_range(7));
            for (int k = 0; k < STAGES; k++) stage_wdata_in[k*DATA_W +: DATA_W] = $urandom;
            tick(1);
        end

        // Counter saturation with a held stall.
        reset_in = 1; hold_in = 0; flush_in = 0; rs1_ren_in = 0; rs2_ren_in = 0; tick(0);
        reset_in = 0; stage_wvld_in = 0; issue(5, 1); tick(1);
        issue(6, 1); rs1_addr_in = 5; rs1_ren_in = 1; rs1_rdata_in = 32'h5A5A; hold_in = 1;
        repeat (65540) tick(0);
        #1;
        check("sat_count", 32'(stall_count_out), 32'hFFFF);
        check("sat_stall", 32'(stallreq_out), 1);

        // Reset in the middle of the stall.
        reset_in = 1; tick(0);
        reset_in = 0;
        #1;
        check("rms_stall", 32'(stallreq_out), 0);
        check("rms_sel1", 32'(fwd1_sel_out), 0);
        check("rms_op1", op1_out, 32'h5A5A);
        check("rms_count", 32'(stall_count_out), 0);
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
